// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, format codes and skid-buffer states for the
// immediate-generation stage.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6,
    FMT_X = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-to-format decode and immediate extraction/extension.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          EN_CSR = 1'b1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_csr;
  logic [XLEN-1:0] imm_zimm;
  logic            unused_funct3;

  // Signed size casts sign-extend from instr[31]; unsigned ones zero-extend.
  assign imm_i    = XLEN'($signed(instr_i[31:20]));
  assign imm_s    = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_b    = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                   instr_i[11:8], 1'b0}));
  assign imm_u    = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign imm_j    = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                   instr_i[30:21], 1'b0}));
  assign imm_csr  = XLEN'(instr_i[31:20]);
  assign imm_zimm = XLEN'(instr_i[19:15]);

  assign unused_funct3 = ^instr_i[13:12];

  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_X;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OP_IMM, LOAD, JALR, MISC_MEM: begin
        fmt_o = FMT_I;
        imm_o = imm_i;
      end
      STORE: begin
        fmt_o = FMT_S;
        imm_o = imm_s;
      end
      BRANCH: begin
        fmt_o = FMT_B;
        imm_o = imm_b;
      end
      LUI, AUIPC: begin
        fmt_o = FMT_U;
        imm_o = imm_u;
      end
      JAL: begin
        fmt_o = FMT_J;
        imm_o = imm_j;
      end
      OP: begin
        fmt_o = FMT_R;
      end
      SYSTEM: begin
        if (EN_CSR && instr_i[14]) begin
          fmt_o = FMT_Z;
          imm_o = imm_zimm;
        end else if (EN_CSR) begin
          fmt_o = FMT_I;
          imm_o = imm_csr;
        end else begin
          fmt_o = FMT_I;
          imm_o = imm_i;
        end
      end
      // Every legal opcode ends in 2'b11, so instr[1:0] != 2'b11 lands here.
      default: begin
        fmt_o     = FMT_X;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decode, PC-relative target adder and
// a 2-entry (main + skid) valid/ready buffer.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          EN_CSR = 1'b1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_target,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [XLEN-1:0]  target;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  res_t            res_d;
  res_t            main_q;
  res_t            skid_q;
  buf_state_e      state_q;
  logic            accept;
  logic            pop;

  imm_decode #(
    .XLEN   (XLEN),
    .EN_CSR (EN_CSR)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    res_d         = '0;
    res_d.imm     = dec_imm;
    res_d.fmt     = dec_fmt;
    res_d.illegal = dec_illegal;
    res_d.target  = in_pc + dec_imm;
    res_d.instr   = in_instr;
    res_d.tag     = in_tag;
  end

  // Ready depends only on buffer state and reset, never on out_ready.
  assign in_ready  = (state_q != BUF_FULL) && !rst;
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_q  <= res_d;
            state_q <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && pop) begin
            main_q <= res_d;
          end else if (accept) begin
            skid_q  <= res_d;
            state_q <= BUF_FULL;
          end else if (pop) begin
            state_q <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= BUF_ONE;
          end
        end
        default: state_q <= BUF_EMPTY;
      endcase
    end
  end

  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_target  = main_q.target;
  assign out_instr   = main_q.instr;
  assign out_tag     = main_q.tag;

endmodule
